// File: rtl/wishbone_interconnect.sv
// Single-master, N-slave Wishbone classic shared-bus interconnect.
// Registers the address decode, routes acks and data back, and answers unmapped or timed-out requests with an error.
module wishbone_interconnect #(
  parameter int unsigned                  NUM_SLAVES     = 2,
  parameter int unsigned                  ADDR_W         = 32,
  parameter int unsigned                  DATA_W         = 64,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE     = {32'h0000_0100, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK     = {32'hFFFF_FF00, 32'hFFFF_FF00},
  parameter int unsigned                  TIMEOUT_CYCLES = 255
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [ADDR_W-1:0]            m_adr_i,
  input  logic [DATA_W-1:0]            m_dat_i,
  input  logic                         m_we_i,
  input  logic                         m_cyc_i,
  input  logic                         m_stb_i,
  output logic [DATA_W-1:0]            m_dat_o,
  output logic                         m_ack_o,
  output logic                         m_err_o,
  output logic [ADDR_W-1:0]            s_adr_o,
  output logic [DATA_W-1:0]            s_dat_o,
  output logic                         s_we_o,
  output logic [NUM_SLAVES-1:0]        s_cyc_o,
  output logic [NUM_SLAVES-1:0]        s_stb_o,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_dat_i,
  input  logic [NUM_SLAVES-1:0]        s_ack_i,
  output logic [7:0]                   err_count_o,
  output logic [ADDR_W-1:0]            last_err_adr_o
);

  localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_BUS, S_RESP, S_ERR, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_W-1:0]     r_adr, w_adr_nxt;
  logic [DATA_W-1:0]     r_dat, w_dat_nxt;
  logic                  r_we, w_we_nxt;
  logic [IDX_W-1:0]      r_sel, w_sel_nxt;
  logic [NUM_SLAVES-1:0] r_stb, w_stb_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0]     r_mdat, w_mdat_nxt;
  logic                  r_ack, w_ack_nxt;
  logic                  r_err, w_err_nxt;
  logic [7:0]            r_err_cnt, w_err_cnt_nxt;
  logic [ADDR_W-1:0]     r_last_err, w_last_err_nxt;

  logic                  w_hit;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_sel_ack;
  logic [DATA_W-1:0]     w_sel_dat;
  logic                  w_timeout;
  logic [7:0]            w_err_cnt_inc;

  // Masked full-width address decode; descending scan so the lowest index wins.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
      if ((m_adr_i & SLAVE_MASK[i*ADDR_W +: ADDR_W]) ==
          (SLAVE_BASE[i*ADDR_W +: ADDR_W] & SLAVE_MASK[i*ADDR_W +: ADDR_W])) begin
        w_hit = 1'b1;
        w_idx = IDX_W'(i);
      end
    end
  end

  assign w_sel_ack     = s_ack_i[r_sel];
  assign w_sel_dat     = s_dat_i[int'(r_sel)*DATA_W +: DATA_W];
  assign w_timeout     = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);
  assign w_err_cnt_inc = (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;

  always_comb begin
    w_state_nxt    = r_state;
    w_adr_nxt      = r_adr;
    w_dat_nxt      = r_dat;
    w_we_nxt       = r_we;
    w_sel_nxt      = r_sel;
    w_stb_nxt      = r_stb;
    w_cnt_nxt      = r_cnt;
    w_mdat_nxt     = r_mdat;
    w_ack_nxt      = 1'b0;
    w_err_nxt      = 1'b0;
    w_err_cnt_nxt  = r_err_cnt;
    w_last_err_nxt = r_last_err;
    case (r_state)
      S_IDLE: begin
        if (m_cyc_i && m_stb_i) begin
          w_adr_nxt = m_adr_i;
          w_dat_nxt = m_dat_i;
          w_we_nxt  = m_we_i;
          if (w_hit) begin
            w_sel_nxt   = w_idx;
            w_stb_nxt   = NUM_SLAVES'(1) << w_idx;
            w_cnt_nxt   = '0;
            w_state_nxt = S_BUS;
          end else begin
            w_err_nxt      = 1'b1;
            w_err_cnt_nxt  = w_err_cnt_inc;
            w_last_err_nxt = m_adr_i;
            w_state_nxt    = S_ERR;
          end
        end
      end
      S_BUS: begin
        if (!m_cyc_i) begin
          w_stb_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else if (w_sel_ack) begin
          w_mdat_nxt  = w_sel_dat;
          w_stb_nxt   = '0;
          w_ack_nxt   = 1'b1;
          w_state_nxt = S_RESP;
        end else if (w_timeout) begin
          w_stb_nxt      = '0;
          w_err_nxt      = 1'b1;
          w_err_cnt_nxt  = w_err_cnt_inc;
          w_last_err_nxt = r_adr;
          w_state_nxt    = S_ERR;
        end else if (r_cnt != '1) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_RESP:  w_state_nxt = S_DONE;
      S_ERR:   w_state_nxt = S_DONE;
      // Hold off until the strobe drops so a held request is not replayed.
      S_DONE:  if (!m_stb_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_adr      <= '0;
      r_dat      <= '0;
      r_we       <= 1'b0;
      r_sel      <= '0;
      r_stb      <= '0;
      r_cnt      <= '0;
      r_mdat     <= '0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_err_cnt  <= '0;
      r_last_err <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_adr      <= w_adr_nxt;
      r_dat      <= w_dat_nxt;
      r_we       <= w_we_nxt;
      r_sel      <= w_sel_nxt;
      r_stb      <= w_stb_nxt;
      r_cnt      <= w_cnt_nxt;
      r_mdat     <= w_mdat_nxt;
      r_ack      <= w_ack_nxt;
      r_err      <= w_err_nxt;
      r_err_cnt  <= w_err_cnt_nxt;
      r_last_err <= w_last_err_nxt;
    end
  end

  assign m_dat_o        = r_mdat;
  assign m_ack_o        = r_ack;
  assign m_err_o        = r_err;
  assign s_adr_o        = r_adr;
  assign s_dat_o        = r_dat;
  assign s_we_o         = r_we;
  assign s_cyc_o        = r_stb;
  assign s_stb_o        = r_stb;
  assign err_count_o    = r_err_cnt;
  assign last_err_adr_o = r_last_err;

endmodule

// File: doc/wishbone_interconnect.md
Name: wishbone_interconnect

Overview:
Parametrised single-master, N-slave Wishbone classic shared-bus interconnect. It sits between the JTAG-driven wishbone_master and the debug-side slaves (DM, LED, UART-print), so several slaves can share one master without contending on data/ack. It registers address decode and routes acks back to the master. It generates an error response for unmapped addresses and for slaves that time out, and keeps error diagnostics.

Parameters:
NUM_SLAVES, 2, number of slave ports (1..8).
ADDR_W, 32, address width.
DATA_W, 64, data width.
SLAVE_BASE, {32'h0000_0100, 32'h0000_0000}, packed NUM_SLAVES*ADDR_W base addresses; slave i occupies bits [i*ADDR_W +: ADDR_W].
SLAVE_MASK, {32'hFFFF_FF00, 32'hFFFF_FF00}, packed NUM_SLAVES*ADDR_W masks; slave i matches when (adr & mask_i) == (base_i & mask_i).
TIMEOUT_CYCLES, 255, cycles in BUS without ack before error; 0 disables the timeout.

Ports:
clk_i  in  1  system clock; the only clock.
rst_i  in  1  reset, asynchronous, active-high.
m_adr_i  in  ADDR_W  master address.
m_dat_i  in  DATA_W  master write data.
m_we_i  in  1  master write enable.
m_cyc_i  in  1  master cycle.
m_stb_i  in  1  master strobe.
m_dat_o  out  DATA_W  read data returned to the master.
m_ack_o  out  1  one-cycle ack to the master.
m_err_o  out  1  one-cycle error to the master.
s_adr_o  out  ADDR_W  shared slave address (registered).
s_dat_o  out  DATA_W  shared slave write data (registered).
s_we_o  out  1  shared slave write enable (registered).
s_cyc_o  out  NUM_SLAVES  per-slave cycle, one-hot or zero.
s_stb_o  out  NUM_SLAVES  per-slave strobe, one-hot or zero.
s_dat_i  in  NUM_SLAVES*DATA_W  packed slave read data.
s_ack_i  in  NUM_SLAVES  per-slave ack.
err_count_o  out  8  saturating count of error responses.
last_err_adr_o  out  ADDR_W  address of the most recent errored request.

Behaviour:
- Reset (async, rst_i=1): state IDLE. All outputs are 0: m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, m_dat_o, err_count_o, last_err_adr_o. Strobes drop in the same instant, including mid-transaction.
- States: IDLE, BUS, RESP, ERR, DONE.
- IDLE: on m_cyc_i & m_stb_i, latch adr/dat/we into s_adr_o/s_dat_o/s_we_o and decode.
  - If any slave matches, the lowest index wins. Next cycle: s_cyc_o[idx]=s_stb_o[idx]=1, state BUS, timeout counter cleared.
  - If no slave matches, go to ERR.
- BUS: wait for s_ack_i[idx]. Acks from non-selected slaves are ignored.
  - On ack: capture s_dat_i slice idx into m_dat_o (on both reads and writes), drop s_cyc_o/s_stb_o, go to RESP.
  - Timeout: the counter increments each BUS cycle. When it reaches TIMEOUT_CYCLES-1 with no ack, drop the slave strobes and go to ERR.
  - If ack and timeout occur in the same cycle, ack wins.
  - If m_cyc_i falls during BUS, abort: drop the slave strobes and go to IDLE without ack or err. Counters are unchanged.
- RESP: m_ack_o=1 for exactly one cycle, then DONE.
- ERR: m_err_o=1 for exactly one cycle. In the same cycle, err_count_o increments, saturating at 255, and last_err_adr_o=s_adr_o. Then DONE.
- DONE: wait until m_stb_i==0, then IDLE. This prevents a held strobe from launching a duplicate transaction.
- Latency: request sampled in cycle 0; slave strobe high in cycle 1; slave ack in cycle k; m_ack_o high in cycle k+1. Minimum master turnaround is 3 cycles.
- m_dat_o holds its value until the next successful ack. m_ack_o and m_err_o are never both high.
- Width rules: decode is a full ADDR_W compare under the mask. The timeout counter is $clog2(TIMEOUT_CYCLES+1) bits wide and never wraps.

Test Plan:
- Read slave 1 at 0x104 with s_dat_i slice1=64'hDEAD_BEEF_0123_4567 and ack 2 cycles after strobe -> s_stb_o=2'b10; m_ack_o one cycle; m_dat_o=64'hDEAD_BEEF_0123_4567; total 4 cycles from request.
- Write 0x08 with data 64'h3F to slave 0 -> s_we_o=1, s_dat_o=64'h3F, s_stb_o=2'b01; ack returns; m_err_o stays 0.
- Unmapped address 0x200 -> no s_stb_o; m_err_o pulses in cycle 1; err_count_o=1; last_err_adr_o=0x200.
- Slave 0 never acks, TIMEOUT_CYCLES=4 -> strobe drops after 4 BUS cycles; m_err_o pulses; err_count_o increments; a later stray s_ack_i[0] is ignored.
- Assert rst_i mid-BUS -> s_cyc_o/s_stb_o=0 immediately, no ack; next request decodes normally.
- Hold m_stb_i high for 10 cycles after ack -> exactly one slave transaction; 256 unmapped requests -> err_count_o saturates at 255.
